switch_input_fifo: RTL and testbench

- Input stage directly upstream of the control unit's IN-instruction path.
- Consumes the debounced board button and the 16 switches, and captures one switch word per button press into a small FIFO.
- Supplies the oldest captured word to the datapath when an IN instruction executes, and stalls the processor while no word is available.
- Replaces the single-flag button handshake with buffered, loss-detecting capture.

---
 rtl/switch_input_fifo.sv | 135 +++++++++++++
 tb/tb_switch_input_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/switch_input_fifo.sv
// Button-triggered switch capture FIFO feeding the IN-instruction path.
// Define SWITCH_SIGN_EXT_EN to sign-extend rd_data instead of zero-extending it.
module switch_input_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       button_in,
    input  logic [DATA_W-1:0]          switches,
    input  logic                       rd_req,
    input  logic                       ovf_clr,
    output logic [31:0]                rd_data,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0] r_sync_r;
    logic                   r_prev_r;
    logic [DATA_W-1:0]      r_sw_r;
    logic [DATA_W-1:0]      r_mem_r [DEPTH];
    logic [AW-1:0]          r_wptr_r;
    logic [AW-1:0]          r_rptr_r;
    logic [CW-1:0]          r_count_r;
    logic                   r_overrun_r;

    logic                   w_push_s;
    logic                   w_pop_s;
    logic                   w_wr_s;
    logic                   w_drop_s;
    logic                   w_empty_s;
    logic                   w_full_s;
    logic [CW-1:0]          w_count_nxt_s;
    logic [31:0]            w_rd_data_s;

    function automatic logic [31:0] extend_word(input logic [DATA_W-1:0] word);
`ifdef SWITCH_SIGN_EXT_EN
        return 32'($signed(word));
`else
        return 32'(word);
`endif
    endfunction

    // Synchronizer and edge-detect reset high so a button held through reset never pushes.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_sync_r <= {SYNC_STAGES{1'b1}};
            r_prev_r <= 1'b1;
        end else begin
            r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], button_in};
            r_prev_r <= r_sync_r[SYNC_STAGES-1];
        end
    end

    // Switch sample register; a push stores the value seen one cycle earlier.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_sw_r <= {DATA_W{1'b0}};
        end else begin
            r_sw_r <= switches;
        end
    end

    // Push/pop qualification and next occupancy.
    always_comb begin
        w_push_s      = r_sync_r[SYNC_STAGES-1] & ~r_prev_r;
        w_empty_s     = (r_count_r == CW'(0));
        w_full_s      = (r_count_r == CW'(DEPTH));
        w_pop_s       = rd_req & ~w_empty_s;
        w_wr_s        = w_push_s & (~w_full_s | w_pop_s);
        w_drop_s      = w_push_s & w_full_s & ~w_pop_s;
        w_count_nxt_s = r_count_r;
        case ({w_wr_s, w_pop_s})
            2'b10:   w_count_nxt_s = r_count_r + CW'(1);
            2'b01:   w_count_nxt_s = r_count_r - CW'(1);
            default: w_count_nxt_s = r_count_r;
        endcase
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (w_wr_s) begin
            r_mem_r[r_wptr_r] <= r_sw_r;
        end
    end

    // Pointers, occupancy and sticky overrun; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_wptr_r    <= {AW{1'b0}};
            r_rptr_r    <= {AW{1'b0}};
            r_count_r   <= {CW{1'b0}};
            r_overrun_r <= 1'b0;
        end else begin
            if (w_wr_s) begin
                r_wptr_r <= r_wptr_r + AW'(1);
            end
            if (w_pop_s) begin
                r_rptr_r <= r_rptr_r + AW'(1);
            end
            r_count_r <= w_count_nxt_s;
            if (w_drop_s) begin
                r_overrun_r <= 1'b1;
            end else if (ovf_clr) begin
                r_overrun_r <= 1'b0;
            end else begin
                r_overrun_r <= r_overrun_r;
            end
        end
    end

    // Head word is visible with zero latency for the single-cycle datapath.
    always_comb begin
        if (w_empty_s) begin
            w_rd_data_s = 32'h0000_0000;
        end else begin
            w_rd_data_s = extend_word(r_mem_r[r_rptr_r]);
        end
    end

    assign rd_data = w_rd_data_s;
    assign stall   = rd_req & w_empty_s;
    assign count   = r_count_r;
    assign empty   = w_empty_s;
    assign full    = w_full_s;
    assign overrun = r_overrun_r;

endmodule

// File: tb/tb_switch_input_fifo.sv
// Directed scoreboard bench for switch_input_fifo (DATA_W=16, DEPTH=4, SYNC_STAGES=2).
module tb_switch_input_fifo;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        button_in = 1'b1;
    logic [15:0] switches = 16'h0000;
    logic        rd_req = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] rd_data;
    logic        stall;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overrun;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb_q [$];

    switch_input_fifo #(.DATA_W(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .rst(rst), .button_in(button_in), .switches(switches),
        .rd_req(rd_req), .ovf_clr(ovf_clr), .rd_data(rd_data), .stall(stall),
        .count(count), .empty(empty), .full(full), .overrun(overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ext(input logic [15:0] v);
`ifdef SWITCH_SIGN_EXT_EN
        return {{16{v[15]}}, v};
`else
        return {16'h0000, v};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    // Press button with a value; the entry is expected after three clock edges.
    task automatic press(input logic [15:0] v, input bit expect_store);
        switches  = v;
        button_in = 1'b1;
        tick(3);
        if (expect_store) sb_q.push_back(ext(v));
        button_in = 1'b0;
        tick(3);
    endtask

    // IN read: head must be visible combinationally, then popped at the edge.
    task automatic read_one(input string tag);
        logic [31:0] exp;
        rd_req = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            exp = 32'd0;
        end else begin
            exp = sb_q.pop_front();
        end
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_data"}, rd_data, exp);
        tick(1);
        rd_req = 1'b0;
    endtask

    initial begin
        // Reset with button held high, then release reset: no push
        tick(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overrun), 32'd0);
        rst = 1'b1;
        tick(4);
        check("held_no_push", 32'(count), 32'd0);
        button_in = 1'b0;
        tick(3);

        // Single press and read
        switches  = 16'h0005;
        button_in = 1'b1;
        tick(2);
        check("lat_count2", 32'(count), 32'd0);
        tick(1);
        check("lat_count3", 32'(count), 32'd1);
        sb_q.push_back(ext(16'h0005));
        button_in = 1'b0;
        tick(3);
        read_one("rd5");
        check("rd5_count", 32'(count), 32'd0);

        // Stalled IN resolved by a later press
        rd_req = 1'b1;
        #1;
        check("stall_empty", 32'(stall), 32'd1);
        check("stall_data", rd_data, 32'd0);
        switches  = 16'h0012;
        button_in = 1'b1;
        tick(2);
        check("stall_hold", 32'(stall), 32'd1);
        tick(1);
        check("stall_drop", 32'(stall), 32'd0);
        check("stall_cnt", 32'(count), 32'd1);
        check("stall_rd", rd_data, ext(16'h0012));
        tick(1);
        check("stall_popped", 32'(count), 32'd0);
        rd_req    = 1'b0;
        button_in = 1'b0;
        tick(3);

        // Overflow: five presses into four entries
        for (int i = 1; i <= 5; i++) press(16'(i), i <= 4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 4; i++) read_one("ovf_rd");
        rd_req = 1'b1;
        #1;
        check("ovf_stall", 32'(stall), 32'd1);
        tick(1);
        rd_req = 1'b0;
        check("ovf_sticky", 32'(overrun), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) press(16'(i), 1'b1);
        check("sim_full", 32'(full), 32'd1);
        switches  = 16'h0009;
        button_in = 1'b1;
        tick(2);
        rd_req = 1'b1;
        #1;
        check("sim_head", rd_data, sb_q.pop_front());
        tick(1);
        rd_req = 1'b0;
        sb_q.push_back(ext(16'h0009));
        check("sim_count", 32'(count), 32'd4);
        check("sim_ovf", 32'(overrun), 32'd0);
        button_in = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) read_one("sim_drain");
        check("sim_empty", 32'(empty), 32'd1);

        // Pointer wrap with one entry in flight
        for (int i = 0; i < 10; i++) begin
            press(16'(i), 1'b1);
            read_one("wrap");
        end
        check("wrap_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-drain during a stalled-style IN
        for (int i = 0; i < 4; i++) press(16'(16'h0020 + i), 1'b1);
        read_one("pre_rst");
        check("pre_rst_cnt", 32'(count), 32'd3);
        rd_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_stall", 32'(stall), 32'd1);
        sb_q.delete();
        rd_req = 1'b0;
        #1;
        check("arst_stall0", 32'(stall), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(3);
        press(16'h8000, 1'b1);
        check("ext_count", 32'(count), 32'd1);
        read_one("ext");
        check("ext_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
